// File: rtl/divider_pkg.sv
// ---------------------------------------------------------------------------
// divider_pkg
//   Shared types and helpers for the sequential restoring divider.
//   - state_t : FSM encoding used by divider. FIXUP is only entered when the
//               design is built with DIVIDER_SIGNED_EN defined.
//   - DIVIDER_DEFAULT_WIDTH / DIVIDER_DEFAULT_CNT_W : default operand width
//               and the matching iteration-counter width.
//   - cntWidth() : iteration-counter width for an arbitrary operand width.
// ---------------------------------------------------------------------------
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DIVIDER_DEFAULT_WIDTH = 32;
  localparam int DIVIDER_DEFAULT_CNT_W = $clog2(DIVIDER_DEFAULT_WIDTH);

  // The counter runs 0..width-1, so $clog2(width) bits are enough; the guard
  // keeps the counter at least one bit wide for degenerate widths.
  function automatic int cntWidth(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/divider_step.sv
// ---------------------------------------------------------------------------
// divider_step
//   One purely combinational restoring-division iteration.
//   Ports:
//     i_partRem     [WIDTH-1:0]  partial remainder before this step
//     i_dividendBit              next dividend bit to shift in (MSB first)
//     i_divisor     [WIDTH-1:0]  divisor magnitude
//     o_partRem     [WIDTH-1:0]  partial remainder after this step
//     o_quotBit                  quotient bit produced by this step
// ---------------------------------------------------------------------------
module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIVIDER_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_partRem,
  input  logic             i_dividendBit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_partRem,
  output logic             o_quotBit
);

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic             w_unusedDiffTop;

  // The shifted remainder is WIDTH+1 bits. The subtraction carries one extra
  // bit above that so the borrow is unambiguous even for a zero divisor,
  // where the shifted value itself can have its top bit set.
  assign w_shifted           = {i_partRem, i_dividendBit};
  assign {w_borrow, w_diff}  = {1'b0, w_shifted} - {2'b00, i_divisor};

  // Bit WIDTH of the difference can only be set when the divisor is zero;
  // in that case it falls off the top exactly like a bit shifted out of the
  // remainder, which is what makes x/0 leave remainder = x.
  assign w_unusedDiffTop     = w_diff[WIDTH];

  // No borrow: keep the difference and emit a 1. Borrow: restore the
  // shifted value and emit a 0.
  assign o_quotBit = ~w_borrow;
  assign o_partRem = w_borrow ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider
//   Sequential restoring radix-2 divider, one quotient bit per clock.
//   Build option: define DIVIDER_SIGNED_EN for two's-complement operands
//   (adds a one-cycle FIXUP state, latency WIDTH+2 instead of WIDTH+1).
//   Ports:
//     clk            system clock, rising edge
//     rst            asynchronous active-high reset
//     dividend       [WIDTH-1:0] numerator, sampled on acceptance
//     divisor        [WIDTH-1:0] denominator, sampled on acceptance
//     data_in_valid  request, accepted in IDLE or DONE
//     quotient       [WIDTH-1:0] result quotient, held until next completion
//     remainder      [WIDTH-1:0] result remainder, held until next completion
//     div_by_zero    divisor was zero, qualified by data_out_valid
//     data_out_valid single-cycle completion pulse
//     busy           division in progress
// ---------------------------------------------------------------------------
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIVIDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             data_in_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             data_out_valid,
  output logic             busy
);

  localparam int               CNT_W    = cntWidth(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_partRem;
  logic [WIDTH-1:0]   r_dvdShift;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_divByZero;

  logic               w_busy;
  logic               w_outValid;
  logic               w_load;
  logic               w_lastStep;
  logic [WIDTH-1:0]   w_stepRem;
  logic               w_stepQbit;
  logic [WIDTH-1:0]   w_quotNext;
  logic [WIDTH-1:0]   w_loadDividend;
  logic [WIDTH-1:0]   w_loadDivisor;

`ifdef DIVIDER_SIGNED_EN
  logic               r_negQuot;
  logic               r_negRem;
  logic               w_negQuotLoad;

  // The datapath only ever sees magnitudes. The most negative value maps to
  // itself, which read as unsigned is exactly its magnitude.
  assign w_loadDividend = dividend[WIDTH-1] ? (-dividend) : dividend;
  assign w_loadDivisor  = divisor[WIDTH-1]  ? (-divisor)  : divisor;

  // A zero divisor must come out as quotient -1 whatever the dividend sign,
  // so the quotient sign correction is suppressed in that case.
  assign w_negQuotLoad  = (dividend[WIDTH-1] ^ divisor[WIDTH-1]) &&
                          (divisor != '0);
`else
  assign w_loadDividend = dividend;
  assign w_loadDivisor  = divisor;
`endif

  assign w_load     = data_in_valid && ((r_state == IDLE) || (r_state == DONE));
  assign w_lastStep = (r_cnt == LAST_CNT);
  assign w_quotNext = {r_dvdShift[WIDTH-2:0], w_stepQbit};

  divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_partRem     (r_partRem),
    .i_dividendBit (r_dvdShift[WIDTH-1]),
    .i_divisor     (r_divisor),
    .o_partRem     (w_stepRem),
    .o_quotBit     (w_stepQbit)
  );

  // State register. Reset drops straight back to IDLE, which also aborts a
  // division in flight without ever reaching DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and status decode. DONE accepts a new request exactly like
  // IDLE so back-to-back divisions lose no cycle. DONE always leaves after a
  // single cycle, so the valid pulse can never stretch.
  always_comb begin
    w_nextState = r_state;
    w_busy      = 1'b0;
    w_outValid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (data_in_valid) begin
          w_nextState = DIVIDE;
        end
      end
      DIVIDE: begin
        w_busy = 1'b1;
`ifdef DIVIDER_SIGNED_EN
        if (w_lastStep) begin
          w_nextState = FIXUP;
        end
`else
        if (w_lastStep) begin
          w_nextState = DONE;
        end
`endif
      end
      FIXUP: begin
        w_busy      = 1'b1;
        w_nextState = DONE;
      end
      DONE: begin
        w_outValid  = 1'b1;
        w_nextState = data_in_valid ? DIVIDE : IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath. The dividend register doubles as the quotient register: every
  // step shifts one dividend bit out of the top and one quotient bit into the
  // bottom, so after WIDTH steps it holds the quotient. Result registers are
  // written on the edge that enters DONE, so they are valid alongside the
  // pulse and stay put until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_partRem   <= '0;
      r_dvdShift  <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divByZero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      r_negQuot   <= 1'b0;
      r_negRem    <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        r_cnt      <= '0;
        r_partRem  <= '0;
        r_dvdShift <= w_loadDividend;
        r_divisor  <= w_loadDivisor;
`ifdef DIVIDER_SIGNED_EN
        r_negQuot  <= w_negQuotLoad;
        r_negRem   <= dividend[WIDTH-1];
`endif
      end else if (r_state == DIVIDE) begin
        r_cnt      <= r_cnt + CNT_W'(1);
        r_partRem  <= w_stepRem;
        r_dvdShift <= w_quotNext;
`ifndef DIVIDER_SIGNED_EN
        if (w_lastStep) begin
          r_quotient  <= w_quotNext;
          r_remainder <= w_stepRem;
          r_divByZero <= (r_divisor == '0);
        end
`endif
      end
`ifdef DIVIDER_SIGNED_EN
      else if (r_state == FIXUP) begin
        r_quotient  <= r_negQuot ? (-r_dvdShift) : r_dvdShift;
        r_remainder <= r_negRem  ? (-r_partRem)  : r_partRem;
        r_divByZero <= (r_divisor == '0);
      end
`endif
    end
  end

  assign quotient       = r_quotient;
  assign remainder      = r_remainder;
  assign div_by_zero    = r_divByZero;
  assign data_out_valid = w_outValid;
  assign busy           = w_busy;

endmodule

// File: tb/tb_divider.sv
// ---------------------------------------------------------------------------
// tb_divider
//   Self-checking bench for divider (WIDTH = 32). Expected results come from
//   plain integer division in refDiv; latency is counted in clock edges with
//   the acceptance edge counted as the first one.
// ---------------------------------------------------------------------------
module tb_divider;

  localparam int WIDTH = 32;
`ifdef DIVIDER_SIGNED_EN
  localparam int LAT = WIDTH + 2;
`else
  localparam int LAT = WIDTH + 1;
`endif
  localparam int TIMEOUT = 100;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             data_in_valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             data_out_valid;
  logic             busy;

  int               errors = 0;
  int               checks = 0;

  logic [WIDTH-1:0] obsQ;
  logic [WIDTH-1:0] obsR;
  logic             obsDbz;
  logic             obsBusyValid;
  logic             obsBusyAccept;
  logic             gotValid;
  int               obsLat;
  int               pulses;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] holdQ;
  logic [WIDTH-1:0] holdR;

  divider #(
    .WIDTH (WIDTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .dividend       (dividend),
    .divisor        (divisor),
    .data_in_valid  (data_in_valid),
    .quotient       (quotient),
    .remainder      (remainder),
    .div_by_zero    (div_by_zero),
    .data_out_valid (data_out_valid),
    .busy           (busy)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: division straight from the arithmetic definition.
  function automatic void refDiv(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                 output logic dbz);
    longint sa;
    longint sb;
    if (b == '0) begin
      q   = '1;
      r   = a;
      dbz = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sa = longint'($signed(a));
      sb = longint'($signed(b));
`else
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
`endif
      q   = WIDTH'(sa / sb);
      r   = WIDTH'(sa % sb);
      dbz = 1'b0;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request, then run until the completion pulse or the timeout.
  // Returns in the DONE cycle, #1 after the edge that raised data_out_valid.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    dividend      = a;
    divisor       = b;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    obsBusyAccept = busy;
    obsLat        = 1;
    while (!data_out_valid && obsLat < TIMEOUT) begin
      @(posedge clk);
      #1;
      obsLat++;
    end
    gotValid     = data_out_valid;
    obsQ         = quotient;
    obsR         = remainder;
    obsDbz       = div_by_zero;
    obsBusyValid = busy;
  endtask

  // Compare the captured completion against the model; optionally step one
  // more cycle and confirm the pulse did not stretch.
  task automatic verifyResult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input string tag, input bit checkTrailing);
    logic [WIDTH-1:0] eq;
    logic [WIDTH-1:0] er;
    logic             ed;
    refDiv(a, b, eq, er, ed);
    checkOutput({tag, "_valid"},     WIDTH'(gotValid), WIDTH'(1));
    checkOutput({tag, "_latency"},   WIDTH'(obsLat), WIDTH'(LAT));
    checkOutput({tag, "_quotient"},  obsQ, eq);
    checkOutput({tag, "_remainder"}, obsR, er);
    checkOutput({tag, "_dbz"},       WIDTH'(obsDbz), WIDTH'(ed));
    checkOutput({tag, "_busyDone"},  WIDTH'(obsBusyValid), WIDTH'(0));
    checkOutput({tag, "_busyRun"},   WIDTH'(obsBusyAccept), WIDTH'(1));
    if (checkTrailing) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_pulseEnd"}, WIDTH'(data_out_valid), WIDTH'(0));
    end
  endtask

  // Count completion pulses over a fixed window of edges.
  task automatic countPulses(input int n, output int count);
    count = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (data_out_valid) count++;
    end
  endtask

  initial begin
    rst           = 1'b1;
    dividend      = '0;
    divisor       = '0;
    data_in_valid = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy",  WIDTH'(busy), WIDTH'(0));
    checkOutput("reset_valid", WIDTH'(data_out_valid), WIDTH'(0));
    checkOutput("reset_dbz",   WIDTH'(div_by_zero), WIDTH'(0));
    checkOutput("reset_q",     quotient, '0);
    checkOutput("reset_r",     remainder, '0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases, including divide by zero and the extremes.
    applyStimulus(32'd100, 32'd7);               verifyResult(32'd100, 32'd7, "basic", 1'b1);
    applyStimulus(32'd5, 32'd0);                 verifyResult(32'd5, 32'd0, "zero", 1'b1);
    applyStimulus(32'd9, 32'd3);                 verifyResult(32'd9, 32'd3, "afterZero", 1'b1);
    applyStimulus(32'hFFFF_FFFF, 32'd1);         verifyResult(32'hFFFF_FFFF, 32'd1, "maxByOne", 1'b1);
    applyStimulus(32'd3, 32'hFFFF_FFFF);         verifyResult(32'd3, 32'hFFFF_FFFF, "smallByMax", 1'b1);
    applyStimulus(32'hFFFF_FFF9, 32'd2);         verifyResult(32'hFFFF_FFF9, 32'd2, "neg7by2", 1'b1);
    applyStimulus(32'd7, 32'hFFFF_FFFE);         verifyResult(32'd7, 32'hFFFF_FFFE, "7byNeg2", 1'b1);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF); verifyResult(32'h8000_0000, 32'hFFFF_FFFF, "minByNeg1", 1'b1);
    applyStimulus(32'hFFFF_FFF9, 32'd0);         verifyResult(32'hFFFF_FFF9, 32'd0, "negByZero", 1'b1);

    // Outputs hold after completion.
    holdQ = quotient;
    holdR = remainder;
    countPulses(6, pulses);
    checkOutput("hold_pulses", WIDTH'(pulses), WIDTH'(0));
    checkOutput("hold_q",      quotient, holdQ);
    checkOutput("hold_r",      remainder, holdR);

    // Randomized operands with a mix of divisor sizes and occasional zero.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 4)
        0:       rb = $urandom;
        1:       rb = WIDTH'($urandom_range(1, 255));
        2:       rb = ra >> $urandom_range(0, 31);
        default: rb = (i % 8 == 3) ? '0 : WIDTH'($urandom_range(1, 15));
      endcase
      applyStimulus(ra, rb);
      verifyResult(ra, rb, $sformatf("rand%0d", i), 1'b1);
    end

    // A request pulsed mid-division is dropped, not queued.
    @(negedge clk);
    dividend      = 32'd1000;
    divisor       = 32'd7;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    obsBusyAccept = busy;
    obsLat        = 1;
    while (!data_out_valid && obsLat < TIMEOUT) begin
      if (obsLat == 5) begin
        dividend      = 32'd50;
        divisor       = 32'd5;
        data_in_valid = 1'b1;
      end else begin
        data_in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      obsLat++;
    end
    data_in_valid = 1'b0;
    gotValid      = data_out_valid;
    obsQ          = quotient;
    obsR          = remainder;
    obsDbz        = div_by_zero;
    obsBusyValid  = busy;
    verifyResult(32'd1000, 32'd7, "ignoreBusy", 1'b1);
    countPulses(LAT + 5, pulses);
    checkOutput("ignoreBusy_noExtra", WIDTH'(pulses), WIDTH'(0));

    // Back-to-back: the second request is raised in the DONE cycle.
    applyStimulus(32'd12345, 32'd10);
    verifyResult(32'd12345, 32'd10, "b2bFirst", 1'b0);
    applyStimulus(32'd77, 32'd4);
    verifyResult(32'd77, 32'd4, "b2bSecond", 1'b1);
    countPulses(LAT + 5, pulses);
    checkOutput("b2b_noExtra", WIDTH'(pulses), WIDTH'(0));

    // Reset ten cycles into a division aborts it silently.
    @(negedge clk);
    dividend      = 32'd1000;
    divisor       = 32'd3;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midReset_busy",  WIDTH'(busy), WIDTH'(0));
    checkOutput("midReset_valid", WIDTH'(data_out_valid), WIDTH'(0));
    checkOutput("midReset_dbz",   WIDTH'(div_by_zero), WIDTH'(0));
    checkOutput("midReset_q",     quotient, '0);
    checkOutput("midReset_r",     remainder, '0);
    @(negedge clk);
    rst = 1'b0;
    countPulses(LAT + 10, pulses);
    checkOutput("midReset_noPulse", WIDTH'(pulses), WIDTH'(0));
    applyStimulus(32'd1000, 32'd3);
    verifyResult(32'd1000, 32'd3, "afterReset", 1'b1);
    checkOutput("afterReset_q333", obsQ, 32'd333);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
